// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of a dual-clock asynchronous FIFO. Everything here runs
// in the read clock domain.
//
// Ports:
//   rclk        in   read-domain clock, rising edge
//   rrst_n      in   asynchronous active-low reset (release synchronised outside)
//   rinc        in   read request from the consumer
//   rwptr_gray  in   Gray write pointer from the write domain (async to rclk)
//   raddr       out  RAM read address (low bits of the binary read pointer)
//   rptr_gray   out  registered Gray read pointer, to the write-side synchroniser
//   rempty      out  registered empty flag
//   rvalid      out  one-cycle strobe: RAM read data for the accepted read valid
//   rlevel      out  occupancy seen from the read domain, 0..2^ADDR_WIDTH
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rwptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rempty,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_rq1_wptr;
  logic [PW-1:0] r_rq2_wptr;
  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_rempty;
  logic          r_rvalid;

  logic          w_acc;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_wbin;

  // A read while empty is dropped entirely.
  assign w_acc        = rinc & ~r_rempty;
  assign w_rbin_next  = r_rbin + {{(PW-1){1'b0}}, w_acc};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Gray-to-binary of the synchronised write pointer: bit i is the XOR of all
  // Gray bits at or above i.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
      assign w_wbin[gi] = ^r_rq2_wptr[PW-1:gi];
    end
  endgenerate

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rq1_wptr <= '0;
      r_rq2_wptr <= '0;
    end else begin
      r_rq1_wptr <= rwptr_gray;
      r_rq2_wptr <= r_rq1_wptr;
    end
  end

  // Pointers, empty and valid. Empty compares the next Gray pointer with the
  // synchronised write pointer sampled before this edge, so the accept that
  // takes the last entry raises empty at the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin   <= '0;
      r_rgray  <= '0;
      r_rempty <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rgray  <= w_rgray_next;
      r_rempty <= (w_rgray_next == r_rq2_wptr);
      r_rvalid <= w_acc;
    end
  end

  assign raddr     = r_rbin[ADDR_WIDTH-1:0];
  assign rptr_gray = r_rgray;
  assign rempty    = r_rempty;
  assign rvalid    = r_rvalid;
  // Modulo subtraction handles pointer wrap; range is 0..depth.
  assign rlevel    = w_wbin - r_rbin;

endmodule
